// File: rtl/priority_enc_pipe.sv
// Two-stage pipelined priority encoder with valid/ready handshakes on both sides.
// Finds the lowest (in_mode=0) or highest (in_mode=1) set bit of a WIDTH-bit word
// and returns the word shifted so the found bit lands at bit 0 / bit WIDTH-1.
// Stage 1 captures the word plus per-nibble hit flags and local indices; stage 2
// combines the nibbles, performs the shift and registers the results.
module priority_enc_pipe #(
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_mode
);

  // Nibble-sized groups keep the stage-1 search shallow; WIDTH >= 4 guarantees one group.
  localparam int GRP = 4;
  localparam int NG  = int'(WIDTH) / GRP;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(WIDTH - 1);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s2_en;
  logic                 s1_advance;
  logic                 in_accept;

  logic [WIDTH-1:0]     s1_data;
  logic                 s1_mode;
  logic [NG-1:0]        s1_hit;
  logic [NG-1:0][1:0]   s1_loc;

  logic [NG-1:0]        grp_hit;
  logic [NG-1:0][1:0]   grp_loc;

  logic                 fin_found;
  logic [IDX_W-1:0]     fin_index;
  logic [WIDTH-1:0]     fin_norm;

  // Stage 2 can take a new word when it is empty or its word leaves this cycle.
  assign s2_en      = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_en;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_accept  = in_valid && in_ready;
  assign out_valid  = s2_valid;

  // Per-nibble hit flag and local index (lowest bit in LSB mode, highest in MSB mode).
  always_comb begin
    grp_hit = '0;
    grp_loc = '0;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < GRP; b++) begin
        if (in_data[g*GRP+b] && (in_mode || !grp_hit[g])) begin
          grp_loc[g] = 2'(b);
        end
        if (in_data[g*GRP+b]) begin
          grp_hit[g] = 1'b1;
        end
      end
    end
  end

  // Pipeline occupancy flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
      end
    end
  end

  // Stage 1 register: word, mode and partial nibble results, loaded only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data <= '0;
      s1_mode <= 1'b0;
      s1_hit  <= '0;
      s1_loc  <= '0;
    end else if (in_accept) begin
      s1_data <= in_data;
      s1_mode <= in_mode;
      s1_hit  <= grp_hit;
      s1_loc  <= grp_loc;
    end
  end

  // Pick the winning nibble, form the full index and normalise the word.
  always_comb begin
    int sel;
    sel       = 0;
    fin_found = 1'b0;
    for (int g = 0; g < NG; g++) begin
      // MSB mode keeps overwriting (highest hit wins); LSB mode keeps the first hit.
      if (s1_hit[g] && (s1_mode || !fin_found)) begin
        sel = g;
      end
      if (s1_hit[g]) begin
        fin_found = 1'b1;
      end
    end
    // With no hit sel and the local index are both zero, so the index and norm are zero.
    fin_index = IDX_W'(sel * GRP + int'(s1_loc[sel]));
    if (s1_mode) begin
      fin_norm = s1_data << (MAX_IDX - fin_index);
    end else begin
      fin_norm = s1_data >> fin_index;
    end
  end

  // Stage 2 register: final outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_found <= 1'b0;
      out_index <= '0;
      out_norm  <= '0;
      out_mode  <= 1'b0;
    end else if (s1_advance) begin
      out_found <= fin_found;
      out_index <= fin_index;
      out_norm  <= fin_norm;
      out_mode  <= s1_mode;
    end
  end

endmodule
